// File: rtl/wpa2_mem_pkg.sv
// wpa2_mem_pkg: shared state encoding and sizing constants for the wpa2 RAM block fetcher
package wpa2_mem_pkg;
    localparam int MEM_ADDR_W = 12;
    localparam int BLK_WORDS = 16;
    localparam int DIG_WORDS = 5;
    localparam logic [3:0] MEM_BE = 4'hF;
    typedef enum logic [2:0] {IDLE, READ, PRESENT, WAIT_DIG, WRITE} state_e;
endpackage

// File: rtl/wpa2_blk_assembler.sv
// wpa2_blk_assembler: 16x32 word register file flattened into a 512-bit block, word0 in the top bits
module wpa2_blk_assembler
    import wpa2_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [3:0]   idx,
    input  logic [31:0]  wdata,
    output logic [511:0] data
);
    logic [31:0] words_q [BLK_WORDS];
    logic [31:0] words_d [BLK_WORDS];
    // overwrite only the addressed slot
    always_comb begin
        words_d = words_q;
        if (we) words_d[idx] = wdata;
    end
    // slot storage, cleared so a discarded block never leaks out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLK_WORDS; i++) words_q[i] <= '0;
        end else begin
            words_q <= words_d;
        end
    end
    for (genvar g = 0; g < BLK_WORDS; g++) begin : g_flat
        assign data[511-32*g -: 32] = words_q[g];
    end
endmodule

// File: rtl/wpa2_mem_block_fetcher.sv
// wpa2_mem_block_fetcher: Avalon-MM master fetching SHA-1 blocks from RAM and writing the digest back
module wpa2_mem_block_fetcher
    import wpa2_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rd_addr,
    input  logic [CNT_W-1:0]  cmd_nblk,
    input  logic [ADDR_W-1:0] cmd_wb_addr,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [511:0]      blk_data,
    output logic              blk_last,
    input  logic              dig_valid,
    output logic              dig_ready,
    input  logic [159:0]      dig_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done
);
    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wb_ptr_q, wb_ptr_d, mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] nblk_q, nblk_d;
    logic [159:0] dig_q, dig_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic cmd_ready_q, cmd_ready_d, blk_valid_q, blk_valid_d, blk_last_q, blk_last_d;
    logic dig_ready_q, dig_ready_d, mem_cs_q, mem_cs_d, mem_we_q, mem_we_d, done_q, done_d;
    logic asm_we;
    wpa2_blk_assembler u_asm (
        .clk   (clk),
        .reset (reset),
        .we    (asm_we),
        .idx   (cnt_q[3:0] - 4'd1),
        .wdata (mem_readdata),
        .data  (blk_data)
    );
    // next-state and next-output decode; every Avalon strobe is prepared one cycle ahead
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wb_ptr_d = wb_ptr_q;
        nblk_d = nblk_q;
        dig_d = dig_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d = mem_wd_q;
        cmd_ready_d = cmd_ready_q;
        blk_valid_d = blk_valid_q;
        blk_last_d = blk_last_q;
        dig_ready_d = dig_ready_q;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        done_d = 1'b0;
        asm_we = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                wb_ptr_d = cmd_wb_addr;
                nblk_d = cmd_nblk;
                if (cmd_nblk == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = READ;
                    cmd_ready_d = 1'b0;
                    cnt_d = '0;
                    mem_cs_d = 1'b1;
                    mem_addr_d = cmd_rd_addr;
                    rd_ptr_d = cmd_rd_addr + 1'b1;
                end
            end
            READ: begin
                cnt_d = cnt_q + 5'd1;
                asm_we = cnt_q != 5'd0;
                if (cnt_q < 5'(BLK_WORDS - 1)) begin
                    mem_cs_d = 1'b1;
                    mem_addr_d = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (cnt_q == 5'(BLK_WORDS)) begin
                    state_d = PRESENT;
                    blk_valid_d = 1'b1;
                    blk_last_d = nblk_q == CNT_W'(1);
                end
            end
            PRESENT: if (blk_ready) begin
                blk_valid_d = 1'b0;
                blk_last_d = 1'b0;
                nblk_d = nblk_q - 1'b1;
                if (nblk_q != CNT_W'(1)) begin
                    state_d = READ;
                    cnt_d = '0;
                    mem_cs_d = 1'b1;
                    mem_addr_d = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    state_d = WAIT_DIG;
                    dig_ready_d = 1'b1;
                end
            end
            WAIT_DIG: if (dig_valid) begin
                state_d = WRITE;
                dig_ready_d = 1'b0;
                dig_d = dig_data << 32;
                cnt_d = '0;
                mem_cs_d = 1'b1;
                mem_we_d = 1'b1;
                mem_addr_d = wb_ptr_q;
                mem_wd_d = dig_data[159:128];
                wb_ptr_d = wb_ptr_q + 1'b1;
            end
            WRITE: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q < 5'(DIG_WORDS - 1)) begin
                    mem_cs_d = 1'b1;
                    mem_we_d = 1'b1;
                    mem_addr_d = wb_ptr_q;
                    mem_wd_d = dig_q[159:128];
                    dig_d = dig_q << 32;
                    wb_ptr_d = wb_ptr_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d = 1'b1;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state, pointers and registered outputs; reset abandons any command in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rd_ptr_q <= '0;
            wb_ptr_q <= '0;
            nblk_q <= '0;
            dig_q <= '0;
            mem_addr_q <= '0;
            mem_wd_q <= '0;
            cmd_ready_q <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_last_q <= 1'b0;
            dig_ready_q <= 1'b0;
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wb_ptr_q <= wb_ptr_d;
            nblk_q <= nblk_d;
            dig_q <= dig_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q <= mem_wd_d;
            cmd_ready_q <= cmd_ready_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q <= blk_last_d;
            dig_ready_q <= dig_ready_d;
            mem_cs_q <= mem_cs_d;
            mem_we_q <= mem_we_d;
            done_q <= done_d;
        end
    end
    assign cmd_ready = cmd_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_last = blk_last_q;
    assign dig_ready = dig_ready_q;
    assign mem_address = mem_addr_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write = mem_we_q;
    assign mem_writedata = mem_wd_q;
    assign mem_byteenable = MEM_BE;
    assign mem_clken = ~reset;
    assign busy = state_q != IDLE;
    assign done = done_q;
endmodule

// File: tb/tb_wpa2_mem_block_fetcher.sv
// tb_wpa2_mem_block_fetcher: randomized scoreboard bench with RAM model and block/digest reference
module tb_wpa2_mem_block_fetcher;
    logic clk = 1'b0, reset;
    logic cmd_valid, cmd_ready, blk_valid, blk_ready, blk_last, dig_valid, dig_ready;
    logic [11:0] cmd_rd_addr, cmd_wb_addr, mem_address;
    logic [7:0] cmd_nblk;
    logic [511:0] blk_data;
    logic [159:0] dig_data;
    logic mem_chipselect, mem_write, mem_clken, busy, done;
    logic [3:0] mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;

    wpa2_mem_block_fetcher dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd_addr(cmd_rd_addr), .cmd_nblk(cmd_nblk), .cmd_wb_addr(cmd_wb_addr),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [4096];
    logic [31:0] ref_mem [4096];
    logic [11:0] rd_q [$];
    logic [43:0] wr_q [$];
    logic [511:0] blk_q [$];
    logic last_q [$];
    int done_q [$];
    int checks = 0, failures = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, cyc = 0, acc_cyc = 0, done_cyc = 0;
    int mode = 0, stall = 0;
    logic cmd_pend = 1'b0, in_cmd = 1'b0;
    logic [11:0] cur_wb;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk)
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else mem_readdata <= ram[mem_address];
        end

    task automatic push_cmd(input logic [11:0] rd, input logic [7:0] n, input logic [11:0] wb);
        logic [511:0] blk;
        logic [11:0] a;
        cur_wb = wb;
        in_cmd = n != 0;
        done_q.push_back(1);
        for (int b = 0; b < int'(n); b++) begin
            blk = '0;
            for (int k = 0; k < 16; k++) begin
                a = 12'(int'(rd) + 16 * b + k);
                rd_q.push_back(a);
                blk = {blk[479:0], ref_mem[a]};
            end
            blk_q.push_back(blk);
            last_q.push_back(b == int'(n) - 1);
        end
    endtask

    task automatic push_dig(input logic [159:0] dig);
        logic [11:0] a;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            a = 12'(int'(cur_wb) + i);
            d = dig[159-32*i -: 32];
            wr_q.push_back({a, d});
            ref_mem[a] = d;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                chk("cmd_spurious", cmd_pend, 1'b1);
                if (cmd_pend) push_cmd(cmd_rd_addr, cmd_nblk, cmd_wb_addr);
                cmd_pend = 1'b0;
                acc_cyc = cyc;
            end
            if (dig_valid && dig_ready) begin
                chk("dig_spurious", {in_cmd, blk_q.size() == 0}, 2'b11);
                push_dig(dig_data);
                in_cmd = 1'b0;
            end
            if (blk_valid && blk_ready) stall = 0;
            else if (blk_valid) stall++;
        end
        @(posedge clk);
        #1;
        cyc++;
        blk_ready = mode == 1 ? stall >= 10 : mode == 2 ? 1'($urandom) : 1'b1;
        dig_valid = mode == 2 ? 1'($urandom) : 1'b1;
        if (mode == 2) dig_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        if (cmd_pend) cmd_valid = 1'b1;
        else if (mode == 2 && in_cmd) begin
            cmd_valid = 1'($urandom);
            cmd_rd_addr = 12'($urandom);
            cmd_nblk = 8'($urandom);
            cmd_wb_addr = 12'($urandom);
        end else cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("clken", mem_clken, 1'b1);
            if (mem_chipselect) begin
                chk("byteenable", mem_byteenable, 4'hF);
                chk("strobe_busy", busy, 1'b1);
                if (mem_write) begin
                    wr_cnt++;
                    chk("wr_pending", wr_q.size() != 0, 1'b1);
                    if (wr_q.size() != 0) chk("wr_addr_data", {mem_address, mem_writedata}, wr_q.pop_front());
                end else begin
                    rd_cnt++;
                    chk("rd_pending", rd_q.size() != 0, 1'b1);
                    if (rd_q.size() != 0) chk("rd_addr", mem_address, rd_q.pop_front());
                end
            end
            if (blk_valid) begin
                chk("blk_pending", blk_q.size() != 0, 1'b1);
                if (blk_q.size() != 0) begin
                    chk("blk_data", blk_data, blk_q[0]);
                    chk("blk_last", blk_last, last_q[0]);
                    if (blk_ready) begin
                        void'(blk_q.pop_front());
                        void'(last_q.pop_front());
                    end
                end
            end
            if (done) begin
                chk("done_expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) void'(done_q.pop_front());
                chk("done_after_all", rd_q.size() + wr_q.size() + blk_q.size(), 0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_cmd(input logic [11:0] rd, input logic [7:0] n, input logic [11:0] wb);
        int rc0 = rd_cnt, wc0 = wr_cnt, d0 = done_cnt, t = 0;
        cmd_rd_addr = rd;
        cmd_nblk = n;
        cmd_wb_addr = wb;
        cmd_pend = 1'b1;
        while (done_cnt == d0 && t < 4000) begin
            tick();
            t++;
        end
        chk("cmd_completed", done_cnt != d0, 1'b1);
        chk("rd_count", rd_cnt - rc0, 16 * int'(n));
        chk("wr_count", wr_cnt - wc0, n == 0 ? 0 : 5);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_hs_outs"}, {blk_valid, blk_last, dig_ready, busy, done}, 5'b0);
        chk({tag, "_blk_data"}, blk_data, 512'b0);
        chk({tag, "_mem"}, {mem_chipselect, mem_write, mem_clken, mem_address, mem_writedata}, 47'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] dg;
        int d0, rc0, t;
        reset = 1'b1;
        {cmd_valid, blk_ready, dig_valid} = '0;
        {cmd_rd_addr, cmd_wb_addr, cmd_nblk, dig_data} = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        for (int i = 0; i < 16; i++) begin
            ram[16 + i] = i;
            ref_mem[16 + i] = i;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst0");
        @(posedge clk);
        #1 reset = 1'b0;

        mode = 0;
        dig_data = {32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        run_cmd(12'h010, 8'd1, 12'h100);
        for (int i = 0; i < 5; i++) chk("t1_ram_wb", ram[12'h100 + i], 32'hA + i);

        mode = 1;
        run_cmd(12'h000, 8'd3, 12'h200);

        mode = 0;
        dg = {$urandom, $urandom, $urandom, $urandom, $urandom};
        dig_data = dg;
        run_cmd(12'hFF8, 8'd1, 12'hFFE);
        chk("t3_wrap_wb", {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001], ram[12'h002]}, dg);

        run_cmd(12'h123, 8'd0, 12'h456);
        chk("t4_done_latency", done_cyc - acc_cyc, 1);
        chk("t4_idle_again", {cmd_ready, busy}, 2'b10);

        rc0 = rd_cnt;
        t = 0;
        cmd_rd_addr = 12'($urandom);
        cmd_nblk = 8'd2;
        cmd_wb_addr = 12'($urandom);
        cmd_pend = 1'b1;
        while (rd_cnt - rc0 < 8 && t < 200) begin
            tick();
            t++;
        end
        chk("t5_reached_word7", rd_cnt - rc0, 8);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk_reset_outputs("t5");
        rd_q.delete();
        wr_q.delete();
        blk_q.delete();
        last_q.delete();
        done_q.delete();
        cmd_pend = 1'b0;
        in_cmd = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();
        chk("t5_no_done", done_cnt, d0);
        run_cmd(12'h040, 8'd2, 12'h300);

        mode = 2;
        for (int c = 0; c < 6; c++)
            run_cmd(12'($urandom), c == 3 ? 8'd0 : 8'($urandom_range(1, 4)), 12'($urandom));
        mode = 0;
        repeat (3) tick();

        chk("queues_empty", rd_q.size() + wr_q.size() + blk_q.size() + done_q.size(), 0);
        t = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) t++;
        chk("ram_image", t, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
